// File: rtl/dmem_mmio_bridge.sv
// Data-side bridge: routes core loads/stores to data RAM or MMIO window.
// MMIO window holds a TX byte FIFO, 64-bit cycle counter and halt register.
module dmem_mmio_bridge #(
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic [31:0] read_address,
  output logic [31:0] DATA_in,
  input  logic        write,
  input  logic [31:0] write_address,
  input  logic [31:0] DATA_out,
  input  logic [1:0]  size,
  output logic        ram_re,
  output logic [31:0] ram_raddr,
  input  logic [31:0] ram_rdata,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_waddr,
  output logic [31:0] ram_wdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] exit_code
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TX_DEPTH);

  logic        w_mmio;
  logic        r_mmio;
  logic [7:0]  w_off;
  logic [7:0]  r_off;
  logic [3:0]  be;
  logic        mmio_wr;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        ovf;
  logic [31:0] rval;
  logic [63:0] cnt;
  logic [31:0] shadow;
  logic        rd_ram_q;
  logic [31:0] mmio_q;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;
  logic [7:0]    mem [TX_DEPTH];

  assign w_mmio = write_address >= MMIO_BASE;
  assign r_mmio = read_address >= MMIO_BASE;
  // Low byte of the offset only depends on low address bits.
  assign w_off  = write_address[7:0] - MMIO_BASE[7:0];
  assign r_off  = read_address[7:0] - MMIO_BASE[7:0];

  always_comb begin
    be        = 4'b1111;
    ram_wdata = DATA_out;
    case (size)
      2'b00: begin
        be        = 4'b0001 << write_address[1:0];
        ram_wdata = {4{DATA_out[7:0]}};
      end
      2'b01: begin
        be        = write_address[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{DATA_out[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        ram_wdata = DATA_out;
      end
    endcase
  end

  assign ram_we    = (write && !w_mmio && !halt && reset) ? be : 4'b0000;
  assign ram_waddr = {write_address[31:2], 2'b00};
  assign ram_re    = read && !r_mmio && reset;
  assign ram_raddr = {read_address[31:2], 2'b00};

  assign full     = count == FULL_CNT;
  assign empty    = count == '0;
  assign mmio_wr  = write && w_mmio && !halt;
  assign push_req = mmio_wr && (w_off == 8'h00);
  assign push     = push_req && !full;
  assign pop      = !empty && tx_ready;
  assign tx_valid = !empty;
  assign tx_data  = mem[rptr];
  assign DATA_in  = rd_ram_q ? ram_rdata : mmio_q;

  always_comb begin
    rval = '0;
    case (r_off)
      8'h04:   rval = {29'b0, ovf, empty, full};
      8'h08:   rval = cnt[31:0];
      8'h0C:   rval = shadow;
      8'h10:   rval = {31'b0, halt};
      default: rval = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      shadow    <= '0;
      rd_ram_q  <= 1'b0;
      mmio_q    <= '0;
      ovf       <= 1'b0;
      halt      <= 1'b0;
      exit_code <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      for (int i = 0; i < TX_DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt <= cnt + 64'd1;
      if (read) begin
        rd_ram_q <= !r_mmio;
        mmio_q   <= r_mmio ? rval : '0;
        if (r_mmio && r_off == 8'h08) shadow <= cnt[63:32];
      end
      if (mmio_wr && w_off == 8'h04) ovf <= 1'b0;
      else if (push_req && full) ovf <= 1'b1;
      if (mmio_wr && w_off == 8'h10) begin
        halt      <= 1'b1;
        exit_code <= DATA_out;
      end
      if (push) begin
        mem[wptr] <= DATA_out[7:0];
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: stores, loads, TX FIFO,
// cycle counter, halt and asynchronous reset behaviour.
module tb_dmem_mmio_bridge;

  logic        clk;
  logic        reset;
  logic        read;
  logic [31:0] read_address;
  logic [31:0] DATA_in;
  logic        write;
  logic [31:0] write_address;
  logic [31:0] DATA_out;
  logic [1:0]  size;
  logic        ram_re;
  logic [31:0] ram_raddr;
  logic [31:0] ram_rdata;
  logic [3:0]  ram_we;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [31:0] exit_code;

  int checks;
  int failures;

  localparam logic [31:0] TX  = 32'h8000_0000;
  localparam logic [31:0] ST  = 32'h8000_0004;
  localparam logic [31:0] CLO = 32'h8000_0008;
  localparam logic [31:0] CHI = 32'h8000_000C;
  localparam logic [31:0] HLT = 32'h8000_0010;

  dmem_mmio_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .read         (read),
    .read_address (read_address),
    .DATA_in      (DATA_in),
    .write        (write),
    .write_address(write_address),
    .DATA_out     (DATA_out),
    .size         (size),
    .ram_re       (ram_re),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .halt         (halt),
    .exit_code    (exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] s);
    write         = 1'b1;
    write_address = a;
    DATA_out      = d;
    size          = s;
  endtask

  task automatic rd(input logic [31:0] a);
    read         = 1'b1;
    read_address = a;
  endtask

  logic [31:0] lo;
  logic [31:0] hi;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    read = 1'b0;
    read_address = '0;
    write = 1'b0;
    write_address = '0;
    DATA_out = '0;
    size = 2'b10;
    ram_rdata = '0;
    tx_ready = 1'b0;

    @(negedge clk);
    wr(32'h0000_0010, 32'hFFFF_FFFF, 2'b10);
    rd(32'h0000_0020);
    #1;
    chk("rst_ram_we", ram_we, 4'b0000);
    chk("rst_ram_re", ram_re, 1'b0);
    chk("rst_data_in", DATA_in, 32'h0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_halt", halt, 1'b0);
    chk("rst_exit", exit_code, 32'h0);
    write = 1'b0;
    read = 1'b0;

    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rd(CLO);
    @(negedge clk);
    chk("cyc_lo_100", DATA_in, 32'd100);
    rd(CHI);
    @(negedge clk);
    chk("cyc_hi_0", DATA_in, 32'd0);
    read = 1'b0;

    wr(32'h0000_0103, 32'h0000_00A5, 2'b00);
    #1;
    chk("sb_we", ram_we, 4'b1000);
    chk("sb_wdata", ram_wdata, 32'hA5A5_A5A5);
    chk("sb_waddr", ram_waddr, 32'h0000_0100);
    @(negedge clk);
    wr(32'h0000_0102, 32'h0000_BEEF, 2'b01);
    #1;
    chk("sh_we", ram_we, 4'b1100);
    chk("sh_wdata", ram_wdata, 32'hBEEF_BEEF);
    @(negedge clk);
    wr(32'h0000_0101, 32'h1234_5678, 2'b01);
    #1;
    chk("sh_mis_we", ram_we, 4'b0011);
    chk("sh_mis_wdata", ram_wdata, 32'h5678_5678);
    @(negedge clk);
    wr(32'h0000_0106, 32'h1122_3344, 2'b11);
    #1;
    chk("sw_we", ram_we, 4'b1111);
    chk("sw_waddr", ram_waddr, 32'h0000_0104);
    chk("sw_wdata", ram_wdata, 32'h1122_3344);
    @(negedge clk);
    write = 1'b0;

    rd(32'h0000_0042);
    #1;
    chk("ld_re", ram_re, 1'b1);
    chk("ld_raddr", ram_raddr, 32'h0000_0040);
    @(negedge clk);
    ram_rdata = 32'h1234_5678;
    rd(32'h0000_0044);
    #1;
    chk("ld_data", DATA_in, 32'h1234_5678);
    @(negedge clk);
    ram_rdata = 32'hCAFE_F00D;
    rd(ST);
    #1;
    chk("b2b_ram", DATA_in, 32'hCAFE_F00D);
    chk("mmio_no_re", ram_re, 1'b0);
    @(negedge clk);
    read = 1'b0;
    ram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("b2b_status", DATA_in, 32'h2);

    @(negedge clk);
    wr(TX, 32'h1, 2'b10);
    #1;
    chk("push_empty_nv", tx_valid, 1'b0);
    @(negedge clk);
    chk("push_empty_v", tx_valid, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      wr(TX, 32'(i), 2'b00);
      @(negedge clk);
    end
    write = 1'b0;
    rd(ST);
    @(negedge clk);
    read = 1'b0;
    chk("st_full_ovf", DATA_in, 32'h5);
    chk("head_stable", tx_data, 8'h01);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_valid", tx_valid, 1'b1);
      chk("drain_data", tx_data, 8'(i));
      @(negedge clk);
    end
    chk("drain_empty", tx_valid, 1'b0);
    wr(ST, 32'h0, 2'b10);
    @(negedge clk);
    write = 1'b0;
    rd(ST);
    @(negedge clk);
    read = 1'b0;
    chk("ovf_clear", DATA_in, 32'h2);

    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr(TX, 32'h11 + 32'(i), 2'b00);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    wr(TX, 32'h15, 2'b00);
    @(negedge clk);
    write = 1'b0;
    tx_ready = 1'b0;
    rd(ST);
    chk("pp_head", tx_data, 8'h12);
    @(negedge clk);
    read = 1'b0;
    chk("pp_status", DATA_in, 32'h4);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pp_drain", tx_data, 8'h12 + 8'(i));
      @(negedge clk);
    end
    chk("pp_dropped", tx_valid, 1'b0);
    tx_ready = 1'b0;
    wr(ST, 32'h0, 2'b10);
    @(negedge clk);
    write = 1'b0;

    force dut.cnt = 64'h0000_0000_FFFF_FFF0;
    @(negedge clk);
    release dut.cnt;
    repeat (30) @(negedge clk);
    rd(CLO);
    @(negedge clk);
    lo = DATA_in;
    rd(CHI);
    @(negedge clk);
    hi = DATA_in;
    read = 1'b0;
    chk("wrap_hi", hi, 32'd1);
    chk("wrap_lo_small", lo < 32'd64, 1'b1);

    wr(TX, 32'h31, 2'b00);
    @(negedge clk);
    wr(TX, 32'h32, 2'b00);
    @(negedge clk);
    write = 1'b0;
    chk("mid_valid", tx_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", tx_valid, 1'b0);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_din", DATA_in, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", tx_valid, 1'b0);

    wr(HLT, 32'h2A, 2'b10);
    @(negedge clk);
    chk("halt_set", halt, 1'b1);
    chk("exit_2a", exit_code, 32'h2A);
    wr(32'h0000_0200, 32'hFFFF_FFFF, 2'b10);
    #1;
    chk("halt_no_we", ram_we, 4'b0000);
    @(negedge clk);
    wr(HLT, 32'h7, 2'b10);
    @(negedge clk);
    chk("exit_kept", exit_code, 32'h2A);
    wr(TX, 32'h99, 2'b00);
    @(negedge clk);
    write = 1'b0;
    chk("halt_no_push", tx_valid, 1'b0);
    rd(HLT);
    @(negedge clk);
    read = 1'b0;
    chk("halt_read", DATA_in, 32'h1);

    wr(32'h0000_0300, 32'h1, 2'b10);
    #2;
    reset = 1'b0;
    #1;
    chk("fin_halt", halt, 1'b0);
    chk("fin_exit", exit_code, 32'h0);
    chk("fin_din", DATA_in, 32'h0);
    chk("fin_we", ram_we, 4'b0000);
    write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
